approx_mult_pipe: RTL and testbench

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pipe_if.sv | 28 ++
 rtl/approx_mult_pipe.sv | 124 ++++++++++++
 tb/tb_approx_mult_pipe.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pipe_if.sv
// Handshake/data bundle for approx_mult_pipe: operand side (in_*), result side (out_*),
// and the approximate-result counter controls.
interface approx_mult_pipe_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            mode;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  z;
    logic            z_mode;
    logic            cnt_clr;
    logic [CW-1:0]   approx_cnt;

    modport master (
        output in_valid, x, y, mode, out_ready, cnt_clr,
        input  in_ready, out_valid, z, z_mode, approx_cnt
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready, cnt_clr,
        output in_ready, out_valid, z, z_mode, approx_cnt
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Two-stage unsigned multiplier with an exact mode and an approximate mode where the low
// L multiplier rows are OR-compressed per column (columns below T dropped).
module approx_mult_pipe #(
    parameter int W  = 8,
    parameter int L  = 2,
    parameter int T  = 5,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mult_pipe_if.slave bus
);
    localparam int HW = 2 * W - L;  // y * x[W-1:L]
    localparam int LW = W + L;      // y * x[L-1:0]
    localparam int AW = W + L - 1;  // OR-compressed columns 0..W+L-2

    logic [W-L-1:0] x_hi;
    logic [L-1:0]   x_lo;
    logic [HW-1:0]  hi_prod;
    logic [LW-1:0]  lo_exact;
    logic [AW-1:0]  lo_approx;
    logic [LW-1:0]  lo_sel;

    logic           s1_valid_q, s1_valid_d;
    logic           s1_mode_q, s1_mode_d;
    logic [HW-1:0]  s1_hi_q, s1_hi_d;
    logic [LW-1:0]  s1_lo_q, s1_lo_d;
    logic           s2_valid_q, s2_valid_d;
    logic [2*W-1:0] z_q, z_d;
    logic           z_mode_q, z_mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           s1_load;
    logic           s2_load;
    logic           accept;
    logic           deliver;

    assign x_hi = bus.x[W-1:L];
    assign x_lo = bus.x[L-1:0];

    // Both modes share the high rows; only the low-row contribution differs, so the
    // final add in stage 2 serves exact and approximate results alike.
    assign hi_prod  = {{(HW-W){1'b0}}, bus.y} * {{W{1'b0}}, x_hi};
    assign lo_exact = {{L{1'b0}}, bus.y} * {{W{1'b0}}, x_lo};

    for (genvar gc = 0; gc < AW; gc++) begin : g_col
        if (gc >= T) begin : g_keep
            logic [L-1:0] terms;
            for (genvar gi = 0; gi < L; gi++) begin : g_row
                if (gc - gi >= 0 && gc - gi < W) begin : g_pp
                    assign terms[gi] = x_lo[gi] & bus.y[gc-gi];
                end else begin : g_none
                    assign terms[gi] = 1'b0;
                end
            end
            assign lo_approx[gc] = |terms;
        end else begin : g_drop
            assign lo_approx[gc] = 1'b0;
        end
    end

    assign lo_sel = bus.mode ? {1'b0, lo_approx} : lo_exact;

    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || s2_load;
    assign accept  = bus.in_valid && s1_load;
    assign deliver = s2_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_hi_d    = s1_hi_q;
        s1_lo_d    = s1_lo_q;
        if (accept) begin
            s1_mode_d = bus.mode;
            s1_hi_d   = hi_prod;
            s1_lo_d   = lo_sel;
        end

        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        z_d        = z_q;
        z_mode_d   = z_mode_q;
        if (s2_load && s1_valid_q) begin
            z_d      = {s1_hi_q, {L{1'b0}}} + {{(W-L){1'b0}}, s1_lo_q};
            z_mode_d = s1_mode_q;
        end

        // Clear beats a coincident increment; the count sticks at all-ones.
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (deliver && z_mode_q && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_hi_q    <= '0;
            s1_lo_q    <= '0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            z_mode_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_hi_q    <= s1_hi_d;
            s1_lo_q    <= s1_lo_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            z_mode_q   <= z_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready   = s1_load;
    assign bus.out_valid  = s2_valid_q;
    assign bus.z          = z_q;
    assign bus.z_mode     = z_mode_q;
    assign bus.approx_cnt = cnt_q;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Drives five differently-parameterised instances from one stimulus stream and checks each
// against a column-by-column arithmetic model plus an in-order result queue.
module tb_approx_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mode, out_ready, cnt_clr;
    logic [31:0] xd, yd;

    int checks = 0;
    int errors = 0;
    int acc0 = 0;
    int del0 = 0;

    int pw  [5] = '{8, 8, 4, 12, 8};
    int pl  [5] = '{2, 2, 1, 3, 4};
    int pt  [5] = '{5, 5, 0, 7, 3};
    int pcw [5] = '{16, 2, 16, 16, 16};

    logic        in_ready_a  [5];
    logic        out_valid_a [5];
    logic [63:0] z_a         [5];
    logic        z_mode_a    [5];
    logic [15:0] cnt_a       [5];

    logic [64:0] exp_q [5][$];
    logic [15:0] cnt_m [5];

    always #5 clk = ~clk;

    approx_mult_pipe_if #(.W(8),  .CW(16)) if0 ();
    approx_mult_pipe_if #(.W(8),  .CW(2))  if1 ();
    approx_mult_pipe_if #(.W(4),  .CW(16)) if2 ();
    approx_mult_pipe_if #(.W(12), .CW(16)) if3 ();
    approx_mult_pipe_if #(.W(8),  .CW(16)) if4 ();

    assign if0.in_valid = in_valid;  assign if0.x = xd[7:0];   assign if0.y = yd[7:0];
    assign if1.in_valid = in_valid;  assign if1.x = xd[7:0];   assign if1.y = yd[7:0];
    assign if2.in_valid = in_valid;  assign if2.x = xd[3:0];   assign if2.y = yd[3:0];
    assign if3.in_valid = in_valid;  assign if3.x = xd[11:0];  assign if3.y = yd[11:0];
    assign if4.in_valid = in_valid;  assign if4.x = xd[7:0];   assign if4.y = yd[7:0];
    assign if0.mode = mode;  assign if0.out_ready = out_ready;  assign if0.cnt_clr = cnt_clr;
    assign if1.mode = mode;  assign if1.out_ready = out_ready;  assign if1.cnt_clr = cnt_clr;
    assign if2.mode = mode;  assign if2.out_ready = out_ready;  assign if2.cnt_clr = cnt_clr;
    assign if3.mode = mode;  assign if3.out_ready = out_ready;  assign if3.cnt_clr = cnt_clr;
    assign if4.mode = mode;  assign if4.out_ready = out_ready;  assign if4.cnt_clr = cnt_clr;

    assign in_ready_a[0] = if0.in_ready;  assign out_valid_a[0] = if0.out_valid;
    assign in_ready_a[1] = if1.in_ready;  assign out_valid_a[1] = if1.out_valid;
    assign in_ready_a[2] = if2.in_ready;  assign out_valid_a[2] = if2.out_valid;
    assign in_ready_a[3] = if3.in_ready;  assign out_valid_a[3] = if3.out_valid;
    assign in_ready_a[4] = if4.in_ready;  assign out_valid_a[4] = if4.out_valid;
    assign z_a[0] = 64'(if0.z);  assign z_mode_a[0] = if0.z_mode;  assign cnt_a[0] = if0.approx_cnt;
    assign z_a[1] = 64'(if1.z);  assign z_mode_a[1] = if1.z_mode;  assign cnt_a[1] = {14'd0, if1.approx_cnt};
    assign z_a[2] = 64'(if2.z);  assign z_mode_a[2] = if2.z_mode;  assign cnt_a[2] = if2.approx_cnt;
    assign z_a[3] = 64'(if3.z);  assign z_mode_a[3] = if3.z_mode;  assign cnt_a[3] = if3.approx_cnt;
    assign z_a[4] = 64'(if4.z);  assign z_mode_a[4] = if4.z_mode;  assign cnt_a[4] = if4.approx_cnt;

    approx_mult_pipe #(.W(8),  .L(2), .T(5), .CW(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    approx_mult_pipe #(.W(8),  .L(2), .T(5), .CW(2))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    approx_mult_pipe #(.W(4),  .L(1), .T(0), .CW(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    approx_mult_pipe #(.W(12), .L(3), .T(7), .CW(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    approx_mult_pipe #(.W(8),  .L(4), .T(3), .CW(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Exact: x*y. Approximate: high rows multiplied normally, low rows OR-ed per column.
    function automatic logic [63:0] model(input int k, input logic [31:0] xr,
                                          input logic [31:0] yr, input logic m);
        int          w, l, t;
        logic [63:0] msk, xv, yv, hi, a;
        logic        b;
        w   = pw[k];
        l   = pl[k];
        t   = pt[k];
        msk = (64'd1 << w) - 64'd1;
        xv  = {32'd0, xr} & msk;
        yv  = {32'd0, yr} & msk;
        if (!m) return xv * yv;
        hi = yv * (xv >> l);
        a  = 64'd0;
        for (int c = t; c <= w + l - 2; c++) begin
            b = 1'b0;
            for (int i = 0; i < l; i++)
                if (c - i >= 0 && c - i < w) b = b | (xv[i] & yv[c-i]);
            if (b) a = a + (64'd1 << c);
        end
        return (hi << l) + a;
    endfunction

    task automatic monitor();
        logic [64:0] e;
        int          n;
        logic [15:0] cmax;
        logic        dmode;
        logic        dlv;
        for (int k = 0; k < 5; k++) begin
            n     = exp_q[k].size();
            dlv   = 1'b0;
            dmode = 1'b0;
            chk($sformatf("d%0d_in_ready", k), in_ready_a[k], (n < 2) || out_ready);
            if (out_valid_a[k] && out_ready) begin
                if (n == 0) begin
                    chk($sformatf("d%0d_spurious_out_valid", k), out_valid_a[k], 0);
                end else begin
                    e     = exp_q[k].pop_front();
                    dlv   = 1'b1;
                    dmode = e[64];
                    chk($sformatf("d%0d_z", k), z_a[k], e[63:0]);
                    chk($sformatf("d%0d_z_mode", k), z_mode_a[k], e[64]);
                    if (k == 0) begin
                        del0++;
                        $display("txn dut0 z=%0d z_mode=%0d expected=%0d", z_a[k], z_mode_a[k], e[63:0]);
                    end
                end
            end
            if (in_valid && in_ready_a[k]) begin
                exp_q[k].push_back({mode, model(k, xd, yd, mode)});
                if (k == 0) acc0++;
            end
            chk($sformatf("d%0d_approx_cnt", k), cnt_a[k], cnt_m[k]);
            cmax = 16'((32'd1 << pcw[k]) - 32'd1);
            if (cnt_clr) cnt_m[k] = 16'd0;
            else if (dlv && dmode && cnt_m[k] != cmax) cnt_m[k] = cnt_m[k] + 16'd1;
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 5; k++) begin
            exp_q[k].delete();
            cnt_m[k] = 16'd0;
        end
    endtask

    task automatic run_one(input logic [31:0] xa, input logic [31:0] ya, input logic m,
                           input logic clr, output logic [63:0] zr, output logic zm);
        xd = xa; yd = ya; mode = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !out_valid_a[0]; i++) tick();
        chk("run_one_out_valid", out_valid_a[0], 1);
        zr = z_a[0];
        zm = z_mode_a[0];
        cnt_clr = clr;
        tick();
        cnt_clr = 1'b0;
    endtask

    int          idx, base, dbase;
    logic [63:0] zr, zh;
    logic        zm;
    int          sx [4] = '{17, 200, 255, 3};
    int          sy [4] = '{99, 255, 128, 1};
    logic        sm [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        xd = 32'd0; yd = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_a[0], 0);
        chk("rst_z", z_a[0], 0);
        chk("rst_z_mode", z_mode_a[0], 0);
        chk("rst_cnt", cnt_a[0], 0);
        chk("rst_in_ready", in_ready_a[0], 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepted on the first edge after release, visible after the second.
        xd = 255; yd = 255; mode = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_after_1_edge", out_valid_a[0], 0);
        tick();
        chk("lat_after_2_edges", out_valid_a[0], 1);
        chk("approx_255x255", z_a[0], 64740);
        chk("approx_255x255_mode", z_mode_a[0], 1);
        tick();
        chk("cnt_after_first", cnt_a[0], 1);

        run_one(255, 255, 1'b0, 1'b0, zr, zm);
        chk("exact_255x255", zr, 65025);
        chk("exact_mode", zm, 0);
        run_one(3, 1, 1'b1, 1'b0, zr, zm);
        chk("approx_3x1", zr, 0);
        run_one(0, 200, 1'b1, 1'b0, zr, zm);
        chk("approx_0x200", zr, 0);

        // Backpressure: only two slots, result held stable, then gap-free drain in order.
        out_ready = 1'b0;
        base = acc0; dbase = del0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin xd = sx[idx]; yd = sy[idx]; mode = sm[idx]; end
            tick();
            idx = acc0 - base;
        end
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", in_ready_a[0], 0);
        zh = z_a[0];
        tick();
        tick();
        chk("stall_z_hold", z_a[0], zh);
        chk("stall_out_valid", out_valid_a[0], 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin xd = sx[idx]; yd = sy[idx]; mode = sm[idx]; end
            chk("stream_nogap", out_valid_a[0], 1);
            tick();
            idx = acc0 - base;
        end
        in_valid = 1'b0;
        chk("stream_delivered", del0 - dbase, 4);
        tick();

        // Saturation on the 2-bit counter, then clear coincident with a delivery.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_cleared", cnt_a[1], 0);
        for (int i = 0; i < 5; i++) run_one(32'(i * 37 + 5), 32'(i * 11 + 9), 1'b1, 1'b0, zr, zm);
        chk("cnt_cw2_saturated", cnt_a[1], 3);
        chk("cnt_cw16_five", cnt_a[0], 5);
        run_one(200, 100, 1'b1, 1'b1, zr, zm);
        chk("cnt_clr_wins_cw2", cnt_a[1], 0);
        chk("cnt_clr_wins_cw16", cnt_a[0], 0);

        // Reset with two results in flight.
        out_ready = 1'b0;
        xd = 77; yd = 88; mode = 1'b1; in_valid = 1'b1;
        tick();
        xd = 99; yd = 11; mode = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("inflight_out_valid", out_valid_a[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_a[0], 0);
        chk("midrst_z", z_a[0], 0);
        chk("midrst_in_ready", in_ready_a[0], 1);
        chk("midrst_cnt", cnt_a[0], 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_no_stale", out_valid_a[0], 0);
        end

        // Random traffic with random backpressure and occasional counter clears.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            cnt_clr   = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 7))
                0:       begin xd = 32'hFFFF_FFFF; yd = $urandom; end
                1:       begin xd = $urandom; yd = 32'hFFFF_FFFF; end
                2:       begin xd = 32'd0; yd = $urandom; end
                default: begin xd = $urandom; yd = $urandom; end
            endcase
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 5; k++) chk($sformatf("d%0d_drained", k), exp_q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
